// File: rtl/reg_bank_responder.sv
// reg_bank_responder
//   Bank of DEPTH registers loaded in parallel by game-logic hardware and
//   read/written by the NIOS II processor over an Avalon-MM slave port with a
//   fixed-latency pipelined read path. A dirty bitmap flags registers loaded
//   by hardware since the processor last read them.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   avs_address         word address: 0..DEPTH-1 data regs, DEPTH status reg
//   avs_read/avs_write  requests; avs_writedata carries write data
//   avs_waitrequest     stalls a write that collides with a hardware load
//   avs_readdata        read data, zero unless avs_readdatavalid
//   avs_readdatavalid   read response strobe, READ_LATENCY after acceptance
//   hw_load_en/hw_data  per-register hardware load enable and packed data
//   reg_out             packed current register contents
//   dirty               per-register dirty bitmap
module reg_bank_responder #(
   parameter int WIDTH        = 16,
   parameter int DEPTH        = 8,
   parameter int ADDR_W       = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic [ADDR_W-1:0]      avs_address,
   input  logic                   avs_read,
   input  logic                   avs_write,
   input  logic [WIDTH-1:0]       avs_writedata,
   output logic                   avs_waitrequest,
   output logic [WIDTH-1:0]       avs_readdata,
   output logic                   avs_readdatavalid,
   input  logic [DEPTH-1:0]       hw_load_en,
   input  logic [DEPTH*WIDTH-1:0] hw_data,
   output logic [DEPTH*WIDTH-1:0] reg_out,
   output logic [DEPTH-1:0]       dirty
);

   localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(DEPTH);

   logic [WIDTH-1:0]        regs_q [DEPTH];
   logic [WIDTH-1:0]        regs_d [DEPTH];
   logic [DEPTH-1:0]        dirty_q, dirty_d;
   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [WIDTH-1:0]        rdat_q [READ_LATENCY];
   logic [WIDTH-1:0]        rdat_d [READ_LATENCY];

   logic             wait_c;
   logic             wr_acc;
   logic             rd_acc;
   logic [WIDTH-1:0] rd_data;
   logic [DEPTH-1:0] dirty_set;
   logic [DEPTH-1:0] dirty_clr;

   // Stall only a write whose target register is being hardware-loaded.
   always_comb begin
      wait_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (avs_write && (avs_address == ADDR_W'(i)) && hw_load_en[i])
            wait_c = 1'b1;
      end
   end

   always_comb begin
      wr_acc    = avs_write && !wait_c;
      // A read issued together with a write is dropped.
      rd_acc    = avs_read && !avs_write;
      rd_data   = '0;
      dirty_set = hw_load_en;
      dirty_clr = '0;

      if (avs_address == STATUS_ADDR) begin
         rd_data = WIDTH'(dirty_q);
         if (wr_acc)
            dirty_clr = avs_writedata[DEPTH-1:0];
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (avs_address == ADDR_W'(i)) begin
            rd_data = regs_q[i];
            if (rd_acc)
               dirty_clr[i] = 1'b1;
            if (wr_acc)
               regs_d[i] = avs_writedata;
         end
         if (hw_load_en[i])
            regs_d[i] = hw_data[i*WIDTH +: WIDTH];
      end

      // Set wins over clear on the same bit.
      dirty_d = (dirty_q & ~dirty_clr) | dirty_set;

      // Data is zeroed on non-response slots so readdata is 0 while not valid.
      vld_d[0]  = rd_acc;
      rdat_d[0] = rd_acc ? rd_data : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         vld_d[i]  = vld_q[i-1];
         rdat_d[i] = rdat_q[i-1];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            regs_q[i] <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++)
            rdat_q[i] <= '0;
         dirty_q <= '0;
         vld_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++)
            regs_q[i] <= regs_d[i];
         for (int unsigned i = 0; i < READ_LATENCY; i++)
            rdat_q[i] <= rdat_d[i];
         dirty_q <= dirty_d;
         vld_q   <= vld_d;
      end
   end

   always_comb begin
      reg_out = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         reg_out[i*WIDTH +: WIDTH] = regs_q[i];
   end

   assign avs_waitrequest   = wait_c;
   assign avs_readdatavalid = vld_q[READ_LATENCY-1];
   assign avs_readdata      = rdat_q[READ_LATENCY-1];
   assign dirty             = dirty_q;

endmodule

// File: tb/tb_reg_bank_responder.sv
// tb_reg_bank_responder
//   Directed bench for reg_bank_responder (WIDTH=16, DEPTH=8, ADDR_W=4,
//   READ_LATENCY=2). Expected read responses are queued with their due
//   cycle when a read is driven and checked when avs_readdatavalid appears.
module tb_reg_bank_responder;

   localparam int W = 16;
   localparam int D = 8;
   localparam int A = 4;
   localparam int L = 2;

   logic           Clk;
   logic           Reset_n;
   logic [A-1:0]   avs_address;
   logic           avs_read;
   logic           avs_write;
   logic [W-1:0]   avs_writedata;
   logic           avs_waitrequest;
   logic [W-1:0]   avs_readdata;
   logic           avs_readdatavalid;
   logic [D-1:0]   hw_load_en;
   logic [D*W-1:0] hw_data;
   logic [D*W-1:0] reg_out;
   logic [D-1:0]   dirty;

   reg_bank_responder #(
      .WIDTH(W), .DEPTH(D), .ADDR_W(A), .READ_LATENCY(L)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
      .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
      .hw_load_en(hw_load_en), .hw_data(hw_data),
      .reg_out(reg_out), .dirty(dirty)
   );

   typedef struct {
      logic [W-1:0] data;
      int           due;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total    = 0;
   int   bad      = 0;
   int   cyc      = 0;
   int   resp_cnt = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Response monitor, sampled on the falling edge.
   always @(negedge Clk) begin
      if (avs_readdatavalid === 1'b1) begin
         resp_cnt++;
         check("resp_expected", 128'(sb.size() > 0), 128'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_data", 128'(avs_readdata), 128'(e.data));
            check("resp_cycle", 128'(cyc), 128'(e.due));
         end
      end else begin
         check("idle_readdata", 128'(avs_readdata), 128'(0));
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle;
      avs_read   = 1'b0;
      avs_write  = 1'b0;
      hw_load_en = '0;
   endtask

   task automatic set_hw(input int i, input logic [W-1:0] v);
      hw_data[i*W +: W] = v;
   endtask

   task automatic rd(input logic [A-1:0] addr, input logic [W-1:0] exp);
      avs_read    = 1'b1;
      avs_address = addr;
      sb.push_back('{exp, cyc + L});
      tick();
      avs_read = 1'b0;
   endtask

   task automatic wr(input logic [A-1:0] addr, input logic [W-1:0] data);
      avs_write     = 1'b1;
      avs_address   = addr;
      avs_writedata = data;
      tick();
      avs_write = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 20 && sb.size() > 0; i++)
         tick();
      check("drain", 128'(sb.size()), 128'(0));
   endtask

   logic [D*W-1:0] prev_out;
   int             cnt0;

   initial begin
      Reset_n       = 1'b0;
      avs_address   = '0;
      avs_writedata = '0;
      hw_data       = '0;
      idle();
      repeat (3) tick();
      check("rst_reg_out", 128'(reg_out), 128'(0));
      check("rst_dirty", 128'(dirty), 128'(0));
      check("rst_wait", 128'(avs_waitrequest), 128'(0));
      check("rst_valid", 128'(avs_readdatavalid), 128'(0));
      Reset_n = 1'b1;
      tick();

      // Reset in the middle of a read: response must never appear.
      hw_load_en = 8'h01;
      set_hw(0, 16'hABCD);
      tick();
      idle();
      check("pre_rst_reg0", 128'(reg_out[15:0]), 128'(16'hABCD));
      avs_read    = 1'b1;
      avs_address = 4'd0;
      tick();
      avs_read = 1'b0;
      Reset_n  = 1'b0;
      #1;
      check("midrst_valid", 128'(avs_readdatavalid), 128'(0));
      repeat (3) tick();
      check("midrst_reg_out", 128'(reg_out), 128'(0));
      check("midrst_dirty", 128'(dirty), 128'(0));
      Reset_n = 1'b1;
      repeat (4) tick();
      check("midrst_no_resp", 128'(resp_cnt), 128'(0));

      // Hardware load then read.
      hw_load_en = 8'h04;
      set_hw(2, 16'hBEEF);
      tick();
      idle();
      check("load_dirty", 128'(dirty), 128'(8'h04));
      check("load_reg2", 128'(reg_out[47:32]), 128'(16'hBEEF));
      rd(4'd2, 16'hBEEF);
      check("read_clr_dirty", 128'(dirty), 128'(8'h00));
      drain();

      // Writes then back-to-back reads; reg0 is read right after its write.
      wr(4'd3, 16'd4);
      wr(4'd2, 16'd3);
      wr(4'd1, 16'd2);
      wr(4'd0, 16'd1);
      check("wr_dirty_unchanged", 128'(dirty), 128'(8'h00));
      rd(4'd0, 16'd1);
      rd(4'd1, 16'd2);
      rd(4'd2, 16'd3);
      rd(4'd3, 16'd4);
      drain();

      // Write/load collision on register 5.
      avs_write     = 1'b1;
      avs_address   = 4'd5;
      avs_writedata = 16'h1111;
      hw_load_en    = 8'h20;
      set_hw(5, 16'h2222);
      #1;
      check("coll_wait_hi", 128'(avs_waitrequest), 128'(1));
      tick();
      hw_load_en = '0;
      #1;
      check("coll_reg5_hw", 128'(reg_out[95:80]), 128'(16'h2222));
      check("coll_wait_lo", 128'(avs_waitrequest), 128'(0));
      tick();
      idle();
      check("coll_reg5", 128'(reg_out[95:80]), 128'(16'h1111));
      check("coll_dirty", 128'(dirty), 128'(8'h20));

      // Status W1C versus same-cycle hardware set.
      wr(4'd8, 16'h00FF);
      check("w1c_all", 128'(dirty), 128'(8'h00));
      hw_load_en = 8'h0F;
      set_hw(0, 16'h0010);
      set_hw(1, 16'h0011);
      set_hw(2, 16'h0012);
      set_hw(3, 16'h0013);
      tick();
      idle();
      check("dirty_0f", 128'(dirty), 128'(8'h0F));
      avs_write     = 1'b1;
      avs_address   = 4'd8;
      avs_writedata = 16'h0003;
      hw_load_en    = 8'h01;
      set_hw(0, 16'h0020);
      #1;
      check("status_no_wait", 128'(avs_waitrequest), 128'(0));
      tick();
      idle();
      check("w1c_set_wins", 128'(dirty), 128'(8'h0D));
      check("w1c_reg0", 128'(reg_out[15:0]), 128'(16'h0020));
      rd(4'd8, 16'h000D);
      drain();
      check("status_read_noeffect", 128'(dirty), 128'(8'h0D));

      // Read and load of reg0 in the same cycle: old value, dirty stays set.
      avs_read    = 1'b1;
      avs_address = 4'd0;
      hw_load_en  = 8'h01;
      set_hw(0, 16'h5A5A);
      sb.push_back('{16'h0020, cyc + L});
      tick();
      idle();
      check("rdload_dirty", 128'(dirty), 128'(8'h0D));
      check("rdload_reg0", 128'(reg_out[15:0]), 128'(16'h5A5A));
      drain();
      rd(4'd2, 16'h0012);
      check("rd2_clr", 128'(dirty), 128'(8'h09));
      drain();

      // Out-of-range address.
      prev_out = reg_out;
      avs_write     = 1'b1;
      avs_address   = 4'd12;
      avs_writedata = 16'hFFFF;
      #1;
      check("oor_wait", 128'(avs_waitrequest), 128'(0));
      tick();
      idle();
      check("oor_reg_out", 128'(reg_out), 128'(prev_out));
      check("oor_dirty", 128'(dirty), 128'(8'h09));
      rd(4'd12, 16'h0000);
      drain();

      // Read and write together: write wins, read dropped (dirty[3] kept).
      cnt0          = resp_cnt;
      avs_read      = 1'b1;
      avs_write     = 1'b1;
      avs_address   = 4'd3;
      avs_writedata = 16'h7777;
      tick();
      idle();
      repeat (4) tick();
      check("rw_reg3", 128'(reg_out[63:48]), 128'(16'h7777));
      check("rw_no_resp", 128'(resp_cnt), 128'(cnt0));
      check("rw_dirty", 128'(dirty), 128'(8'h09));

      check("sb_empty", 128'(sb.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
